// File: rtl/mtimer.sv
// RISC-V machine timer: 64-bit mtime/mtimecmp on APB, NRZ tick input, registered level irq.
// Latency: tick to mtime +1 in one cycle, compare to irq one cycle; APB has no wait states (pready tied 1).
module mtimer (
   input  logic        clk,
   input  logic        rst,
   input  logic        apbs_psel,
   input  logic        apbs_penable,
   input  logic        apbs_pwrite,
   input  logic [19:0] apbs_paddr,
   input  logic [31:0] apbs_pwdata,
   output logic [31:0] apbs_prdata,
   output logic        apbs_pready,
   output logic        apbs_pslverr,
   input  logic        mtime_tick_nrz,
   output logic        timer_irq
);

   localparam logic [2:0] REG_CTRL      = 3'd0;
   localparam logic [2:0] REG_MTIME     = 3'd2;
   localparam logic [2:0] REG_MTIMEH    = 3'd3;
   localparam logic [2:0] REG_MTIMECMP  = 3'd4;
   localparam logic [2:0] REG_MTIMECMPH = 3'd5;
   localparam logic [2:0] REG_STATUS    = 3'd6;

   logic [63:0] mtime;
   logic [63:0] mtimecmp;
   logic        en;
   logic        nrz_prev;
   logic        armed;

   logic [2:0]  reg_sel;
   logic        wr;
   logic        tick;
   logic        unused_paddr;

   assign reg_sel      = apbs_paddr[4:2];
   assign unused_paddr = ^{apbs_paddr[19:5], apbs_paddr[1:0]};
   assign wr           = apbs_psel & apbs_penable & apbs_pwrite;

   // armed masks the first post-reset cycle so the reset-release level of the NRZ input never counts
   assign tick = armed & (mtime_tick_nrz != nrz_prev);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mtime     <= 64'd0;
         mtimecmp  <= 64'hffff_ffff_ffff_ffff;
         en        <= 1'b1;
         nrz_prev  <= 1'b0;
         armed     <= 1'b0;
         timer_irq <= 1'b0;
      end else begin
         nrz_prev  <= mtime_tick_nrz;
         armed     <= 1'b1;
         timer_irq <= (mtime >= mtimecmp);

         if (wr && reg_sel == REG_CTRL)
            en <= apbs_pwdata[0];

         // a software write to either mtime half wins over a coincident tick, which is dropped
         if (wr && reg_sel == REG_MTIME)
            mtime[31:0] <= apbs_pwdata;
         else if (wr && reg_sel == REG_MTIMEH)
            mtime[63:32] <= apbs_pwdata;
         else if (tick && en)
            mtime <= mtime + 64'd1;

         if (wr && reg_sel == REG_MTIMECMP)
            mtimecmp[31:0] <= apbs_pwdata;
         if (wr && reg_sel == REG_MTIMECMPH)
            mtimecmp[63:32] <= apbs_pwdata;
      end
   end

   always_comb begin
      apbs_prdata  = 32'd0;
      apbs_pslverr = 1'b0;
      if (apbs_psel) begin
         case (reg_sel)
            REG_CTRL:      apbs_prdata = {31'd0, en};
            REG_MTIME:     apbs_prdata = mtime[31:0];
            REG_MTIMEH:    apbs_prdata = mtime[63:32];
            REG_MTIMECMP:  apbs_prdata = mtimecmp[31:0];
            REG_MTIMECMPH: apbs_prdata = mtimecmp[63:32];
            REG_STATUS:    apbs_prdata = {31'd0, timer_irq};
            default:       apbs_pslverr = 1'b1;
         endcase
      end
   end

   assign apbs_pready = 1'b1;

endmodule

// File: tb/tb_mtimer.sv
// Directed bench for mtimer: register map, tick counting, carry/wrap, irq timing, collisions, errors, reset.
module tb_mtimer;

   logic        clk;
   logic        rst;
   logic        apbs_psel;
   logic        apbs_penable;
   logic        apbs_pwrite;
   logic [19:0] apbs_paddr;
   logic [31:0] apbs_pwdata;
   logic [31:0] apbs_prdata;
   logic        apbs_pready;
   logic        apbs_pslverr;
   logic        mtime_tick_nrz;
   logic        timer_irq;

   int n_total = 0;
   int n_fail  = 0;

   mtimer dut (
      .clk            (clk),
      .rst            (rst),
      .apbs_psel      (apbs_psel),
      .apbs_penable   (apbs_penable),
      .apbs_pwrite    (apbs_pwrite),
      .apbs_paddr     (apbs_paddr),
      .apbs_pwdata    (apbs_pwdata),
      .apbs_prdata    (apbs_prdata),
      .apbs_pready    (apbs_pready),
      .apbs_pslverr   (apbs_pslverr),
      .mtime_tick_nrz (mtime_tick_nrz),
      .timer_irq      (timer_irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called just after a negedge; returns just after a later negedge with the bus idle.
   task automatic apb_write(input logic [19:0] addr, input logic [31:0] data, output logic err);
      apbs_psel    = 1'b1;
      apbs_penable = 1'b0;
      apbs_pwrite  = 1'b1;
      apbs_paddr   = addr;
      apbs_pwdata  = data;
      @(negedge clk);
      apbs_penable = 1'b1;
      #1;
      err = apbs_pslverr;
      @(negedge clk);
      apbs_psel    = 1'b0;
      apbs_penable = 1'b0;
      apbs_pwrite  = 1'b0;
   endtask

   task automatic apb_read(input logic [19:0] addr, output logic [31:0] data, output logic err);
      apbs_psel    = 1'b1;
      apbs_penable = 1'b0;
      apbs_pwrite  = 1'b0;
      apbs_paddr   = addr;
      @(negedge clk);
      apbs_penable = 1'b1;
      #1;
      data = apbs_prdata;
      err  = apbs_pslverr;
      @(negedge clk);
      apbs_psel    = 1'b0;
      apbs_penable = 1'b0;
   endtask

   task automatic toggle_wait(input int cycles);
      mtime_tick_nrz = ~mtime_tick_nrz;
      repeat (cycles) @(negedge clk);
   endtask

   logic [31:0] rd;
   logic        er;

   initial begin
      rst            = 1'b1;
      apbs_psel      = 1'b0;
      apbs_penable   = 1'b0;
      apbs_pwrite    = 1'b0;
      apbs_paddr     = 20'd0;
      apbs_pwdata    = 32'd0;
      mtime_tick_nrz = 1'b1;

      // reset state with the NRZ input held high
      repeat (3) @(negedge clk);
      #1;
      check("rst_irq", timer_irq, 0);
      check("rst_prdata_idle", apbs_prdata, 0);
      check("rst_pslverr_idle", apbs_pslverr, 0);
      check("rst_pready", apbs_pready, 1);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      apb_read(20'h00, rd, er); check("rst_ctrl", rd, 1); check("rst_ctrl_err", er, 0);
      apb_read(20'h08, rd, er); check("rst_mtime", rd, 0);
      apb_read(20'h0c, rd, er); check("rst_mtimeh", rd, 0);
      apb_read(20'h10, rd, er); check("rst_cmp", rd, 32'hffff_ffff);
      apb_read(20'h14, rd, er); check("rst_cmph", rd, 32'hffff_ffff);
      apb_read(20'h18, rd, er); check("rst_status", rd, 0);
      #1;
      check("rst_irq_after", timer_irq, 0);

      // five toggles, one every four clocks
      for (int i = 0; i < 5; i++) toggle_wait(4);
      apb_read(20'h08, rd, er); check("five_ticks", rd, 5);

      // carry into high word
      apb_write(20'h08, 32'hffff_ffff, er);
      apb_write(20'h0c, 32'h0, er);
      toggle_wait(2);
      apb_read(20'h08, rd, er); check("carry_lo", rd, 0);
      apb_read(20'h0c, rd, er); check("carry_hi", rd, 1);

      // full 64-bit wrap
      apb_write(20'h08, 32'hffff_ffff, er);
      apb_write(20'h0c, 32'hffff_ffff, er);
      toggle_wait(2);
      apb_read(20'h08, rd, er); check("wrap_lo", rd, 0);
      apb_read(20'h0c, rd, er); check("wrap_hi", rd, 0);

      // compare at 10, one tick per clock from 0, watching MTIME continuously
      apb_write(20'h10, 32'd10, er);
      apb_write(20'h14, 32'd0, er);
      @(negedge clk);
      #1;
      check("cmp10_irq_pre", timer_irq, 0);
      apbs_psel    = 1'b1;
      apbs_penable = 1'b1;
      apbs_pwrite  = 1'b0;
      apbs_paddr   = 20'h08;
      for (int i = 1; i <= 10; i++) begin
         mtime_tick_nrz = ~mtime_tick_nrz;
         @(negedge clk);
         #1;
         check($sformatf("count_%0d", i), apbs_prdata, i);
         check($sformatf("irq_low_%0d", i), timer_irq, 0);
      end
      @(negedge clk);
      #1;
      check("count_hold", apbs_prdata, 10);
      check("irq_rise", timer_irq, 1);
      apbs_psel    = 1'b0;
      apbs_penable = 1'b0;

      // raise compare to 100: irq drops two cycles after the write
      apbs_psel    = 1'b1;
      apbs_pwrite  = 1'b1;
      apbs_paddr   = 20'h10;
      apbs_pwdata  = 32'd100;
      @(negedge clk);
      apbs_penable = 1'b1;
      @(negedge clk);
      apbs_psel    = 1'b0;
      apbs_penable = 1'b0;
      apbs_pwrite  = 1'b0;
      #1;
      check("irq_w1", timer_irq, 1);
      @(negedge clk);
      #1;
      check("irq_w2", timer_irq, 0);

      // write to MTIME coincident with a toggle
      apbs_psel    = 1'b1;
      apbs_pwrite  = 1'b1;
      apbs_paddr   = 20'h08;
      apbs_pwdata  = 32'h0000_1234;
      @(negedge clk);
      apbs_penable   = 1'b1;
      mtime_tick_nrz = ~mtime_tick_nrz;
      @(negedge clk);
      apbs_psel    = 1'b0;
      apbs_penable = 1'b0;
      apbs_pwrite  = 1'b0;
      apb_read(20'h08, rd, er); check("collide_lo", rd, 32'h1234);
      apb_read(20'h0c, rd, er); check("collide_hi", rd, 0);

      // disabled counter discards ticks; re-enable adds none
      apb_write(20'h00, 32'h0, er);
      apb_read(20'h00, rd, er); check("ctrl_off", rd, 0);
      for (int i = 0; i < 3; i++) toggle_wait(2);
      apb_read(20'h08, rd, er); check("en0_hold", rd, 32'h1234);
      apb_write(20'h00, 32'hffff_ffff, er);
      repeat (3) @(negedge clk);
      apb_read(20'h00, rd, er); check("ctrl_on", rd, 1);
      apb_read(20'h08, rd, er); check("reenable_hold", rd, 32'h1234);
      toggle_wait(2);
      apb_read(20'h08, rd, er); check("reenable_tick", rd, 32'h1235);

      // unmapped offsets
      apb_read(20'h04, rd, er);  check("rd04_data", rd, 0); check("rd04_err", er, 1);
      apb_read(20'h1c, rd, er);  check("rd1c_data", rd, 0); check("rd1c_err", er, 1);
      apb_write(20'h04, 32'h0, er);         check("wr04_err", er, 1);
      apb_write(20'h1c, 32'hdead_beef, er); check("wr1c_err", er, 1);
      apb_write(20'h18, 32'h0, er);         check("wr18_err", er, 0);
      apb_read(20'h00, rd, er); check("unm_ctrl", rd, 1);
      apb_read(20'h08, rd, er); check("unm_mtime", rd, 32'h1235);
      apb_read(20'h0c, rd, er); check("unm_mtimeh", rd, 0);
      apb_read(20'h10, rd, er); check("unm_cmp", rd, 100);
      apb_read(20'h14, rd, er); check("unm_cmph", rd, 0);
      apb_read(20'h18, rd, er); check("status_irq", rd, 1); check("status_err", er, 0);

      // asynchronous reset during the access phase of a write
      apbs_psel    = 1'b1;
      apbs_pwrite  = 1'b1;
      apbs_paddr   = 20'h14;
      apbs_pwdata  = 32'd5;
      @(negedge clk);
      apbs_penable = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      check("arst_irq", timer_irq, 0);
      @(negedge clk);
      apbs_psel    = 1'b0;
      apbs_penable = 1'b0;
      apbs_pwrite  = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      apb_read(20'h14, rd, er); check("arst_cmph", rd, 32'hffff_ffff);
      apb_read(20'h08, rd, er); check("arst_mtime", rd, 0);
      apb_read(20'h00, rd, er); check("arst_ctrl", rd, 1);

      $display("%0d/%0d checks passed", n_total - n_fail, n_total);
      $finish;
   end

endmodule
